// File: rtl/mc_control_unit.sv
// ============================================================================
// Module   : mc_control_unit
// Function : ARM-subset control unit. Decodes the instruction, evaluates its
//            condition against a registered NZCV flag register, and sequences
//            the MUL/DIV unit through a start/done handshake with PC stall and
//            a one-cycle write-back. The abort timeout exists only when the
//            MC_TIMEOUT_EN macro is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_control_unit #(
    parameter int MC_MAX_CYC = 64,
    parameter int CNT_W      = $clog2(MC_MAX_CYC + 1)
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    input  logic        MDone,
    output logic        PCSrc,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        ALUSrc,
    output logic [1:0]  ImmSrc,
    output logic [2:0]  RegSrc,
    output logic [1:0]  ALUControl,
    output logic        MStart,
    output logic        MCycleOp,
    output logic        MWrite,
    output logic        Busy,
    output logic [3:0]  Flags,
    output logic        MErr
);

    localparam logic [1:0] c_OP_DP  = 2'b00;
    localparam logic [1:0] c_OP_MEM = 2'b01;
    localparam logic [1:0] c_OP_BR  = 2'b10;

    localparam logic [1:0] c_ALU_ADD = 2'b00;
    localparam logic [1:0] c_ALU_SUB = 2'b01;
    localparam logic [1:0] c_ALU_AND = 2'b10;
    localparam logic [1:0] c_ALU_ORR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MC_RUN = 2'd1,
        S_MC_WB  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_flags;
    logic        w_is_mc;
    logic        w_branch;
    logic        w_reg_w;
    logic        w_mem_w;
    logic [1:0]  w_flag_w;
    logic        w_cond_ex;
    logic        w_issue;
    logic        w_timeout;
    logic        w_merr;
    logic        w_n;
    logic        w_z;
    logic        w_c;
    logic        w_v;
    logic        w_unused;

    assign w_unused = ^{Instr[19:8], Instr[3:0]};
    assign w_is_mc  = (Instr[27:26] == c_OP_DP) && !Instr[25] && (Instr[7:4] == 4'b1001);

    // w_flag_w: [1] = N/Z write, [0] = C/V write
    always_comb begin
        w_branch   = 1'b0;
        w_reg_w    = 1'b0;
        w_mem_w    = 1'b0;
        w_flag_w   = 2'b00;
        MemtoReg   = 1'b0;
        ALUSrc     = 1'b0;
        ImmSrc     = 2'b00;
        RegSrc     = 3'b000;
        ALUControl = c_ALU_ADD;
        MCycleOp   = 1'b0;
        if (w_is_mc) begin
            RegSrc   = 3'b100;
            MCycleOp = Instr[21];
        end else begin
            case (Instr[27:26])
                c_OP_DP: begin
                    ALUSrc = Instr[25];
                    case (Instr[24:21])
                        4'b0000: begin ALUControl = c_ALU_AND; w_reg_w = 1'b1; w_flag_w = {Instr[20], 1'b0};  end
                        4'b0010: begin ALUControl = c_ALU_SUB; w_reg_w = 1'b1; w_flag_w = {2{Instr[20]}};    end
                        4'b0100: begin ALUControl = c_ALU_ADD; w_reg_w = 1'b1; w_flag_w = {2{Instr[20]}};    end
                        4'b1100: begin ALUControl = c_ALU_ORR; w_reg_w = 1'b1; w_flag_w = {Instr[20], 1'b0};  end
                        4'b1010: begin ALUControl = c_ALU_SUB; w_flag_w = 2'b11; end
                        4'b1011: begin ALUControl = c_ALU_ADD; w_flag_w = 2'b11; end
                        default: ;
                    endcase
                end
                c_OP_MEM: begin
                    ALUSrc     = 1'b1;
                    ImmSrc     = 2'b01;
                    ALUControl = Instr[23] ? c_ALU_ADD : c_ALU_SUB;
                    if (Instr[20]) begin
                        w_reg_w  = 1'b1;
                        MemtoReg = 1'b1;
                    end else begin
                        w_mem_w = 1'b1;
                        RegSrc  = 3'b010;
                    end
                end
                c_OP_BR: begin
                    w_branch = 1'b1;
                    ALUSrc   = 1'b1;
                    ImmSrc   = 2'b10;
                    RegSrc   = 3'b001;
                end
                default: ;
            endcase
        end
    end

    assign {w_n, w_z, w_c, w_v} = r_flags;

    always_comb begin
        w_cond_ex = 1'b0;
        case (Instr[31:28])
            4'b0000: w_cond_ex = w_z;
            4'b0001: w_cond_ex = !w_z;
            4'b0010: w_cond_ex = w_c;
            4'b0011: w_cond_ex = !w_c;
            4'b0100: w_cond_ex = w_n;
            4'b0101: w_cond_ex = !w_n;
            4'b0110: w_cond_ex = w_v;
            4'b0111: w_cond_ex = !w_v;
            4'b1000: w_cond_ex = w_c && !w_z;
            4'b1001: w_cond_ex = !w_c || w_z;
            4'b1010: w_cond_ex = (w_n == w_v);
            4'b1011: w_cond_ex = (w_n != w_v);
            4'b1100: w_cond_ex = !w_z && (w_n == w_v);
            4'b1101: w_cond_ex = w_z || (w_n != w_v);
            4'b1110: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    // The abort-pulse cycle retires the held op, so it must not re-issue it.
    assign w_issue = (r_state == S_IDLE) && !w_merr;

    always_comb begin
        w_state_next = r_state;
        MStart       = 1'b0;
        MWrite       = 1'b0;
        Busy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_is_mc && w_cond_ex && w_issue && RESETn) begin
                    MStart       = 1'b1;
                    Busy         = 1'b1;
                    w_state_next = S_MC_RUN;
                end
            end
            S_MC_RUN: begin
                Busy = 1'b1;
                if (MDone) begin
                    w_state_next = S_MC_WB;
                end else if (w_timeout) begin
                    w_state_next = S_IDLE;
                end
            end
            S_MC_WB: begin
                MWrite       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign PCSrc    = w_branch && w_cond_ex && w_issue;
    assign RegWrite = w_reg_w  && w_cond_ex && w_issue;
    assign MemWrite = w_mem_w  && w_cond_ex && w_issue;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state <= S_IDLE;
            r_flags <= 4'b0000;
        end else begin
            r_state <= w_state_next;
            if (w_flag_w[1] && w_cond_ex && w_issue) begin
                r_flags[3:2] <= ALUFlags[3:2];
            end
            if (w_flag_w[0] && w_cond_ex && w_issue) begin
                r_flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    assign Flags = r_flags;

`ifdef MC_TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt;
    logic             r_merr;

    assign w_timeout = (r_state == S_MC_RUN) && ((r_cnt + CNT_W'(1)) == CNT_W'(MC_MAX_CYC));

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_cnt  <= '0;
            r_merr <= 1'b0;
        end else begin
            r_cnt  <= (r_state == S_MC_RUN) ? (r_cnt + CNT_W'(1)) : '0;
            r_merr <= w_timeout && !MDone;
        end
    end

    assign w_merr = r_merr;
`else
    logic w_unused_cfg;

    assign w_unused_cfg = (MC_MAX_CYC > CNT_W);
    assign w_timeout    = 1'b0;
    assign w_merr       = 1'b0;
`endif

    assign MErr = w_merr;

endmodule

`default_nettype wire

// File: tb/tb_mc_control_unit.sv
// ============================================================================
// Module   : tb_mc_control_unit
// Function : Self-checking bench for mc_control_unit; random and directed
//            stimulus against a behavioural decode/condition/flag model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_control_unit;

    localparam int          c_MAX = 8;
    localparam logic [31:0] c_NOP = 32'hEC00_0000;
    localparam logic [3:0]  c_CMDS [6] = '{4'b0000, 4'b0010, 4'b0100, 4'b1100, 4'b1010, 4'b1011};

    logic        CLK = 1'b0;
    logic        RESETn;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        MDone;
    logic        PCSrc, RegWrite, MemWrite, MemtoReg, ALUSrc;
    logic [1:0]  ImmSrc;
    logic [2:0]  RegSrc;
    logic [1:0]  ALUControl;
    logic        MStart, MCycleOp, MWrite, Busy;
    logic [3:0]  Flags;
    logic        MErr;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [3:0]  m_flags;

    mc_control_unit #(.MC_MAX_CYC(c_MAX)) dut (
        .CLK(CLK), .RESETn(RESETn), .Instr(Instr), .ALUFlags(ALUFlags), .MDone(MDone),
        .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .ALUSrc(ALUSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
        .MStart(MStart), .MCycleOp(MCycleOp), .MWrite(MWrite), .Busy(Busy),
        .Flags(Flags), .MErr(MErr)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mk_dp(input logic [3:0] cc, input logic [3:0] cmd, input logic s);
        return {cc, 2'b00, 1'b0, cmd, s, 4'd0, 4'd1, 8'h00, 4'd2};
    endfunction

    function automatic logic [31:0] mk_mc(input logic [3:0] cc, input logic div);
        return {cc, 2'b00, 1'b0, 3'b000, div, 1'b0, 4'd1, 4'd0, 4'd2, 4'b1001, 4'd3};
    endfunction

    function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cc)
            4'h0: return z;            4'h1: return !z;
            4'h2: return c;            4'h3: return !c;
            4'h4: return n;            4'h5: return !n;
            4'h6: return v;            4'h7: return !v;
            4'h8: return c && !z;      4'h9: return !c || z;
            4'hA: return n == v;       4'hB: return n != v;
            4'hC: return !z && n == v; 4'hD: return z || n != v;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Vector order: PCSrc RegWrite MemWrite MemtoReg ALUSrc ImmSrc RegSrc ALUControl MCycleOp
    function automatic void model_single(input logic [31:0] ins, input logic [3:0] f,
                                         output logic [12:0] e, output logic [12:0] m,
                                         output logic [1:0] fupd);
        logic ce, pcs, rw, mw, m2r, asrc, known, writes, arith;
        logic [1:0] imm, alu;
        ce = cond_ok(ins[31:28], f);
        pcs = 1'b0; rw = 1'b0; mw = 1'b0; m2r = 1'b0; asrc = 1'b0;
        imm = 2'b00; alu = 2'b00; known = 1'b1; writes = 1'b1; arith = 1'b1;
        m = 13'b1110000000000;
        fupd = 2'b00;
        case (ins[27:26])
            2'b00: begin
                case (ins[24:21])
                    4'b0000: begin alu = 2'b10; arith = 1'b0; end
                    4'b0010: alu = 2'b01;
                    4'b0100: alu = 2'b00;
                    4'b1100: begin alu = 2'b11; arith = 1'b0; end
                    4'b1010: begin alu = 2'b01; writes = 1'b0; end
                    4'b1011: begin alu = 2'b00; writes = 1'b0; end
                    default: known = 1'b0;
                endcase
                if (known) begin
                    rw   = writes && ce;
                    asrc = ins[25];
                    m    = 13'b1111111100110;
                    if (ce && (ins[20] || !writes)) fupd = arith ? 2'b11 : 2'b10;
                end
            end
            2'b01: begin
                rw  = ins[20] && ce;
                mw  = !ins[20] && ce;
                m2r = ins[20];
                imm = 2'b01;
                alu = ins[23] ? 2'b00 : 2'b01;
                m   = {3'b111, ins[20], 9'b011100110};
            end
            2'b10: begin
                pcs = ce;
                imm = 2'b10;
                m   = 13'b1110011100000;
            end
            default: ;
        endcase
        e = {pcs, rw, mw, m2r, asrc, imm, 3'b000, alu, 1'b0};
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [3:0] alu);
        @(posedge CLK); #1;
        Instr = ins; ALUFlags = alu; MDone = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RESETn = 1'b0; Instr = mk_mc(4'hE, 1'b0); ALUFlags = 4'hF; MDone = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        n_cmp++; if (Flags !== 4'b0000) begin n_err++; $display("FAIL reset_flags got=%b exp=0000", Flags); end
        n_cmp++; if ({MStart, Busy, MWrite, MErr} !== 4'b0000) begin n_err++;
            $display("FAIL reset_ctrl got=%b exp=0000", {MStart, Busy, MWrite, MErr}); end
        n_cmp++; if ({RegSrc[2], MCycleOp} !== 2'b10) begin n_err++;
            $display("FAIL reset_decode got=%b exp=10", {RegSrc[2], MCycleOp}); end
        Instr = c_NOP; MDone = 1'b0;
        @(posedge CLK); #1;
        RESETn = 1'b1; m_flags = 4'b0000;
    endtask

    task automatic test_flags_directed();
        drive(mk_dp(4'hE, 4'b0100, 1'b1), 4'b0110);
        n_cmp++; if (RegWrite !== 1'b1) begin n_err++; $display("FAIL adds_regwrite got=%b exp=1", RegWrite); end
        drive(mk_dp(4'h0, 4'b0100, 1'b0), 4'b1111);
        n_cmp++; if (Flags !== 4'b0110) begin n_err++; $display("FAIL adds_flags got=%b exp=0110", Flags); end
        n_cmp++; if (RegWrite !== 1'b1) begin n_err++; $display("FAIL addeq_regwrite got=%b exp=1", RegWrite); end
        drive(mk_dp(4'h1, 4'b0100, 1'b0), 4'b0000);
        n_cmp++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL addne_regwrite got=%b exp=0", RegWrite); end
        drive(mk_dp(4'hE, 4'b1010, 1'b0), 4'b1001);
        n_cmp++; if ({RegWrite, Flags} !== 5'b0_0110) begin n_err++;
            $display("FAIL cmp_regwrite got=%b exp=00110", {RegWrite, Flags}); end
        drive(mk_dp(4'hE, 4'b0000, 1'b1), 4'b0100);
        n_cmp++; if (Flags !== 4'b1001) begin n_err++; $display("FAIL cmp_flags got=%b exp=1001", Flags); end
        drive(c_NOP, 4'b1111);
        n_cmp++; if (Flags !== 4'b0101) begin n_err++; $display("FAIL ands_flags got=%b exp=0101", Flags); end
        m_flags = 4'b0101;
    endtask

    task automatic test_mul_latency();
        int n_start, n_busy, n_wb, start_cyc, wb_cyc;
        logic op;
        n_start = 0; n_busy = 0; n_wb = 0; start_cyc = 0; wb_cyc = 0; op = 1'bx;
        for (int c = 1; c <= 8; c++) begin
            @(posedge CLK); #1;
            Instr = (c <= 7) ? mk_mc(4'hE, 1'b0) : c_NOP;
            ALUFlags = 4'($urandom); MDone = (c == 6);
            @(negedge CLK);
            if (MStart) begin n_start++; start_cyc = c; op = MCycleOp; end
            if (Busy) n_busy++;
            if (MWrite) begin n_wb++; wb_cyc = c; end
        end
        n_cmp++; if (n_start != 1 || start_cyc != 1) begin n_err++;
            $display("FAIL mul_mstart got=%0d@%0d exp=1@1", n_start, start_cyc); end
        n_cmp++; if (n_busy != 6) begin n_err++; $display("FAIL mul_busy_cycles got=%0d exp=6", n_busy); end
        n_cmp++; if (n_wb != 1 || wb_cyc != 7) begin n_err++;
            $display("FAIL mul_mwrite got=%0d@%0d exp=1@7", n_wb, wb_cyc); end
        n_cmp++; if (op !== 1'b0) begin n_err++; $display("FAIL mul_mcycleop got=%b exp=0", op); end
    endtask

    task automatic test_mc_seq(input logic [3:0] cc, input logic div, input int d);
        logic taken;
        logic [3:0] f0;
        logic [6:0] exp_v, got_v;
        taken = cond_ok(cc, m_flags);
        f0 = m_flags;
        for (int c = 0; c <= d + 1; c++) begin
            @(posedge CLK); #1;
            Instr = mk_mc(cc, div); ALUFlags = 4'($urandom); MDone = (c == d);
            @(negedge CLK);
            exp_v = {taken && c == 0, taken && c <= d, taken && c == d + 1, 4'b0000};
            got_v = {MStart, Busy, MWrite, MErr, PCSrc, RegWrite, MemWrite};
            n_cmp++; if (got_v !== exp_v) begin n_err++;
                $display("FAIL mc_seq cc=%h div=%b d=%0d c=%0d got=%b exp=%b", cc, div, d, c, got_v, exp_v); end
            if (c == 0) begin
                n_cmp++; if ({RegSrc[2], MCycleOp} !== {1'b1, div}) begin n_err++;
                    $display("FAIL mc_decode got=%b exp=%b", {RegSrc[2], MCycleOp}, {1'b1, div}); end
            end
        end
        @(posedge CLK); #1;
        Instr = c_NOP; MDone = 1'b0;
        @(negedge CLK);
        n_cmp++; if ({Flags, Busy} !== {f0, 1'b0}) begin n_err++;
            $display("FAIL mc_after got=%b exp=%b", {Flags, Busy}, {f0, 1'b0}); end
    endtask

    task automatic test_divne();
        drive(mk_dp(4'hE, 4'b0100, 1'b1), 4'b0100);
        drive(c_NOP, 4'b0000);
        n_cmp++; if (Flags !== 4'b0100) begin n_err++; $display("FAIL divne_setup got=%b exp=0100", Flags); end
        m_flags = 4'b0100;
        test_mc_seq(4'h1, 1'b1, 2);
    endtask

    task automatic test_random_single(input int n);
        logic [31:0] ins;
        logic [12:0] e, m, g;
        logic [1:0]  fu;
        logic [3:0]  alu;
        for (int i = 0; i < n; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 1) == 1) ins[24:21] = c_CMDS[$urandom_range(0, 5)];
            if ($urandom_range(0, 3) == 0) ins[31:28] = 4'hE;
            if (ins[27:26] == 2'b00 && !ins[25] && ins[7:4] == 4'b1001) ins[4] = 1'b0;
            alu = 4'($urandom);
            @(posedge CLK); #1;
            Instr = ins; ALUFlags = alu; MDone = 1'($urandom_range(0, 1));
            model_single(ins, m_flags, e, m, fu);
            @(negedge CLK);
            g = {PCSrc, RegWrite, MemWrite, MemtoReg, ALUSrc, ImmSrc, RegSrc, ALUControl, MCycleOp};
            n_cmp++; if ((g & m) !== (e & m)) begin n_err++;
                $display("FAIL decode instr=%h flags=%b got=%b exp=%b mask=%b", ins, m_flags, g, e, m); end
            n_cmp++; if ({MStart, Busy, MWrite, MErr} !== 4'b0000) begin n_err++;
                $display("FAIL idle_ctrl instr=%h got=%b exp=0000", ins, {MStart, Busy, MWrite, MErr}); end
            n_cmp++; if (Flags !== m_flags) begin n_err++;
                $display("FAIL flags instr=%h got=%b exp=%b", ins, Flags, m_flags); end
            if (fu[1]) m_flags[3:2] = alu[3:2];
            if (fu[0]) m_flags[1:0] = alu[1:0];
        end
    endtask

    task automatic test_mc_random(input int n);
        for (int i = 0; i < n; i++) begin
            test_mc_seq(4'($urandom), 1'($urandom), $urandom_range(1, c_MAX));
        end
    endtask

    task automatic test_reset_mid_run();
        drive(mk_dp(4'hE, 4'b0100, 1'b1), 4'b1010);
        drive(mk_mc(4'hE, 1'b0), 4'b0000);
        drive(mk_mc(4'hE, 1'b0), 4'b0000);
        drive(mk_mc(4'hE, 1'b0), 4'b0000);
        n_cmp++; if ({Busy, Flags} !== 5'b1_1010) begin n_err++;
            $display("FAIL midrun_busy got=%b exp=11010", {Busy, Flags}); end
        #2;
        RESETn = 1'b0; Instr = c_NOP;
        #1;
        n_cmp++; if ({MStart, Busy, MWrite, MErr, Flags} !== 8'b0) begin n_err++;
            $display("FAIL midrun_reset got=%b exp=00000000", {MStart, Busy, MWrite, MErr, Flags}); end
        @(posedge CLK); #1;
        RESETn = 1'b1; MDone = 1'b1; m_flags = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            n_cmp++; if ({MWrite, Busy, MErr, Flags} !== 7'b0) begin n_err++;
                $display("FAIL late_mdone c=%0d got=%b exp=0000000", c, {MWrite, Busy, MErr, Flags}); end
            @(posedge CLK); #1;
            MDone = 1'b0;
        end
    endtask

    task automatic test_timeout();
`ifdef MC_TIMEOUT_EN
        int done_at;
        logic [3:0] exp_v, got_v;
        for (int k = 0; k < 2; k++) begin
            done_at = (k == 0) ? 0 : c_MAX;
            for (int c = 0; c <= c_MAX + 2; c++) begin
                @(posedge CLK); #1;
                Instr = (c <= c_MAX + 1) ? mk_mc(4'hE, 1'b1) : c_NOP;
                ALUFlags = 4'($urandom); MDone = (done_at != 0) && (c == done_at);
                @(negedge CLK);
                exp_v = {c == 0, c <= c_MAX, done_at != 0 && c == c_MAX + 1, done_at == 0 && c == c_MAX + 1};
                got_v = {MStart, Busy, MWrite, MErr};
                n_cmp++; if (got_v !== exp_v) begin n_err++;
                    $display("FAIL timeout done_at=%0d c=%0d got=%b exp=%b", done_at, c, got_v, exp_v); end
            end
        end
`else
        test_mc_seq(4'hE, 1'b1, 3 * c_MAX);
`endif
    endtask

    initial begin
        #500000;
        n_err++;
        $display("FAIL watchdog time=%0t exp=finish before 500000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESETn = 1'b0; Instr = c_NOP; ALUFlags = 4'b0000; MDone = 1'b0; m_flags = 4'b0000;
        test_reset();
        test_flags_directed();
        test_mul_latency();
        test_divne();
        test_random_single(300);
        test_mc_random(40);
        test_reset_mid_run();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
